mem_bus_arbiter: RTL

//  Shares the single CPU memory port between instruction fetch (IF) and load/store (LS) requesters.
//  - Sits between the IFU/LSU request interfaces and the memory bus, and runs one transaction at a time.
//  - LS has fixed priority, bounded by an IF anti-starvation counter.
//  - Each response is registered and routed back to the requester that owns the transaction.

---
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single CPU memory port between instruction fetch (IF) and load/store (LS),
// one transaction at a time. Optional response watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_rsp_err,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_we,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                ls_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err,

    output logic                busy,
    output logic                grant_owner
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SC_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;

    logic [1:0]        state;
    logic [SC_W-1:0]   starve_cnt;
    logic              if_win;
    logic              ls_win;
    logic              accept;
    logic              req_handshake;
    logic              wd_expire;
    logic              rsp_fire;
    logic              rsp_err_next;
    logic [DATA_W-1:0] rsp_data_next;

    // IF overrides LS priority only once LS has been granted STARVE_MAX times in a row while IF waited.
    always_comb begin
        if_win = if_req_valid && (!ls_req_valid || (starve_cnt == STARVE_LIM));
        ls_win = ls_req_valid && !if_win;
    end

    assign if_req_ready  = (state == S_IDLE) && if_win && !reset;
    assign ls_req_ready  = (state == S_IDLE) && ls_win && !reset;
    assign accept        = if_req_ready || ls_req_ready;
    assign req_handshake = mem_req_valid && mem_req_ready;
    assign busy          = (state != S_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

    logic [WD_W-1:0] wd_cnt;

    // Fires on the TIMEOUT_CYCLES-th WAIT_RSP cycle; a real response in that cycle still wins.
    assign wd_expire = (state == S_WAIT_RSP) && !mem_rsp_valid &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state != S_WAIT_RSP) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expire          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    assign rsp_fire = (state == S_WAIT_RSP) && (mem_rsp_valid || wd_expire);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rsp_err_next  = 1'b1;
        rsp_data_next = '0;
        if (mem_rsp_valid) begin
            rsp_err_next  = mem_rsp_err;
            rsp_data_next = mem_req_we ? '0 : mem_rsp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (accept)        state <= S_REQ;
                S_REQ:      if (req_handshake) state <= S_WAIT_RSP;
                S_WAIT_RSP: if (rsp_fire)      state <= S_IDLE;
                default:                       state <= S_IDLE;
            endcase
        end
    end

    // Request fields stay latched after the handshake so the response path can still see mem_req_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            grant_owner   <= 1'b0;
        end else if (accept) begin
            mem_req_valid <= 1'b1;
            grant_owner   <= ls_win;
            if (ls_win) begin
                mem_req_addr  <= ls_req_addr;
                mem_req_we    <= ls_req_we;
                mem_req_wdata <= ls_req_wdata;
                mem_req_wstrb <= ls_req_wstrb;
            end else begin
                mem_req_addr  <= if_req_addr;
                mem_req_we    <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wstrb <= {STRB_W{1'b0}};
            end
        end else if (req_handshake) begin
            mem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_req_ready) begin
            starve_cnt <= '0;
        end else if (ls_req_ready) begin
            if (!if_req_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            ls_rsp_err   <= 1'b0;
        end else begin
            if_rsp_valid <= rsp_fire && !grant_owner;
            ls_rsp_valid <= rsp_fire && grant_owner;
            if_rsp_err   <= rsp_fire && !grant_owner && rsp_err_next;
            ls_rsp_err   <= rsp_fire && grant_owner && rsp_err_next;
            if (rsp_fire && !grant_owner) begin
                if_rsp_data <= rsp_data_next;
            end
            if (rsp_fire && grant_owner) begin
                ls_rsp_data <= rsp_data_next;
            end
        end
    end

endmodule
